// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, command sub-ops and FSM state type for the 7-segment controller
package seg7_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] MAX_IDX = 3'd5;
  localparam logic [6:0] SEG7_OFF = 7'h7F;
  localparam logic [6:0] SEG7_0 = 7'h40;
  localparam logic [6:0] SEG7_1 = 7'h79;
  localparam logic [6:0] SEG7_2 = 7'h24;
  localparam logic [6:0] SEG7_3 = 7'h30;
  localparam logic [6:0] SEG7_4 = 7'h19;
  localparam logic [6:0] SEG7_5 = 7'h12;
  localparam logic [6:0] SEG7_6 = 7'h02;
  localparam logic [6:0] SEG7_7 = 7'h78;
  localparam logic [6:0] SEG7_8 = 7'h00;
  localparam logic [6:0] SEG7_9 = 7'h10;
  localparam logic [6:0] SEG7_A = 7'h08;
  localparam logic [6:0] SEG7_B = 7'h03;
  localparam logic [6:0] SEG7_C = 7'h46;
  localparam logic [6:0] SEG7_D = 7'h21;
  localparam logic [6:0] SEG7_E = 7'h06;
  localparam logic [6:0] SEG7_F = 7'h0E;
  localparam logic [2:0] OP_BLANK_ALL = 3'd0;
  localparam logic [2:0] OP_BLANK = 3'd1;
  localparam logic [2:0] OP_SET_BLINK = 3'd2;
  localparam logic [2:0] OP_RAW = 3'd3;
  typedef enum logic [1:0] {IDLE, ARG, CLR} state_t;
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: 4-bit value to active-low {g,f,e,d,c,b,a} pattern
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  always_comb
    case (val)
      4'h0: seg = SEG7_0;
      4'h1: seg = SEG7_1;
      4'h2: seg = SEG7_2;
      4'h3: seg = SEG7_3;
      4'h4: seg = SEG7_4;
      4'h5: seg = SEG7_5;
      4'h6: seg = SEG7_6;
      4'h7: seg = SEG7_7;
      4'h8: seg = SEG7_8;
      4'h9: seg = SEG7_9;
      4'hA: seg = SEG7_A;
      4'hB: seg = SEG7_B;
      4'hC: seg = SEG7_C;
      4'hD: seg = SEG7_D;
      4'hE: seg = SEG7_E;
      default: seg = SEG7_F;
    endcase
endmodule

// File: rtl/seg7_disp_ctrl.sv
// seg7_disp_ctrl: byte-command controller for six active-low 7-segment digits with blink and blank sweep
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int BLINK_DIV_W   = 24,
  parameter int ARG_TIMEOUT_W = 16
) (
  input  logic       CLOCK_50,
  input  logic       Reset_7Seg,
  input  logic       Cmd_Valid,
  input  logic [7:0] Cmd_Byte,
  output logic       Cmd_Ready,
  output logic       Cmd_Err,
  output logic       Busy,
  output logic [6:0] Seg_0,
  output logic [6:0] Seg_1,
  output logic [6:0] Seg_2,
  output logic [6:0] Seg_3,
  output logic [6:0] Seg_4,
  output logic [6:0] Seg_5
);
  state_t state_q, state_d;
  logic raw_q, raw_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] clr_q, clr_d;
  logic [ARG_TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [BLINK_DIV_W-1:0] presc_q, presc_d;
  logic phase_q, phase_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic err_q, err_d;
  logic [6:0] digit_q [NUM_DIGITS];
  logic [6:0] digit_d [NUM_DIGITS];
  logic [6:0] seg_q [NUM_DIGITS];
  logic [6:0] seg_d [NUM_DIGITS];
  logic [6:0] hex_seg;
  logic fire;
  logic [2:0] sub, lo;

  seg7_hex_decoder u_dec (.val(Cmd_Byte[3:0]), .seg(hex_seg));

  assign Cmd_Ready = state_q != CLR;
  assign Busy = state_q == CLR;
  assign Cmd_Err = err_q;
  assign fire = Cmd_Valid & Cmd_Ready;
  assign sub = Cmd_Byte[6:4];
  assign lo = Cmd_Byte[2:0];
  assign {Seg_5, Seg_4, Seg_3, Seg_2, Seg_1, Seg_0} = {seg_q[5], seg_q[4], seg_q[3], seg_q[2], seg_q[1], seg_q[0]};

  always_comb begin
    state_d = state_q;
    raw_d = raw_q;
    idx_d = idx_q;
    clr_d = clr_q;
    tmo_d = tmo_q;
    mask_d = mask_q;
    err_d = 1'b0;
    digit_d = digit_q;
    presc_d = presc_q + 1'b1;
    phase_d = phase_q ^ (&presc_q);
    case (state_q)
      IDLE:
        if (fire) begin
          if (!Cmd_Byte[7]) begin
            if (sub > MAX_IDX) err_d = 1'b1;
            else digit_d[sub] = hex_seg;
          end else if (sub == OP_BLANK_ALL) begin
            state_d = CLR;
            clr_d = 3'd0;
          end else if (sub == OP_SET_BLINK) begin
            state_d = ARG;
            raw_d = 1'b0;
            tmo_d = '0;
          end else if (sub > OP_RAW || lo > MAX_IDX) begin
            err_d = 1'b1;
          end else if (sub == OP_BLANK) begin
            digit_d[lo] = SEG7_OFF;
          end else begin
            state_d = ARG;
            raw_d = 1'b1;
            idx_d = lo;
            tmo_d = '0;
          end
        end
      ARG:
        if (fire) begin
          state_d = IDLE;
          if (raw_q) digit_d[idx_q] = Cmd_Byte[6:0];
          else mask_d = Cmd_Byte[NUM_DIGITS-1:0];
        end else if (&tmo_q) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      CLR: begin
        digit_d[clr_q] = SEG7_OFF;
        clr_d = clr_q + 1'b1;
        if (clr_q == MAX_IDX) begin
          state_d = IDLE;
          mask_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // phase_q high means the blink-off half period
    for (int i = 0; i < NUM_DIGITS; i++) seg_d[i] = (mask_q[i] & phase_q) ? SEG7_OFF : digit_q[i];
  end

  always_ff @(posedge CLOCK_50 or posedge Reset_7Seg)
    if (Reset_7Seg) begin
      state_q <= IDLE;
      raw_q <= 1'b0;
      idx_q <= '0;
      clr_q <= '0;
      tmo_q <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
      mask_q <= '0;
      err_q <= 1'b0;
      digit_q <= '{default: SEG7_OFF};
      seg_q <= '{default: SEG7_OFF};
    end else begin
      state_q <= state_d;
      raw_q <= raw_d;
      idx_q <= idx_d;
      clr_q <= clr_d;
      tmo_q <= tmo_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      mask_q <= mask_d;
      err_q <= err_d;
      digit_q <= digit_d;
      seg_q <= seg_d;
    end
endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// tb_seg7_disp_ctrl: directed and random command streams checked against a behavioural display model
module tb_seg7_disp_ctrl;
  localparam int TMO = 1 << 16;
  localparam int HALF = 16;
  localparam logic [6:0] HEX_TB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 1'b0;
  logic Reset_7Seg, Cmd_Valid, Cmd_Ready, Cmd_Err, Busy;
  logic [7:0] Cmd_Byte;
  logic [6:0] seg [6];
  int checks = 0, failures = 0;
  logic [6:0] m_dig [6];
  logic [5:0] m_mask;
  int sweep, pend, p_idx, age, ncyc;
  bit last_hs;

  seg7_disp_ctrl #(.BLINK_DIV_W(4), .ARG_TIMEOUT_W(16)) dut (
    .CLOCK_50(clk), .Reset_7Seg(Reset_7Seg), .Cmd_Valid(Cmd_Valid), .Cmd_Byte(Cmd_Byte),
    .Cmd_Ready(Cmd_Ready), .Cmd_Err(Cmd_Err), .Busy(Busy),
    .Seg_0(seg[0]), .Seg_1(seg[1]), .Seg_2(seg[2]), .Seg_3(seg[3]), .Seg_4(seg[4]), .Seg_5(seg[5]));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit take(logic [7:0] b);
    logic [2:0] s, lo;
    s = b[6:4];
    lo = b[2:0];
    if (pend != 0) begin
      if (pend == 2) m_dig[p_idx] = b[6:0];
      else m_mask = b[5:0];
      pend = 0;
      return 0;
    end
    if (!b[7]) begin
      if (s > 5) return 1;
      m_dig[s] = HEX_TB[b[3:0]];
      return 0;
    end
    case (s)
      3'd0: sweep = 0;
      3'd1: begin
        if (lo > 5) return 1;
        m_dig[lo] = 7'h7F;
      end
      3'd2: begin pend = 1; age = 0; end
      3'd3: begin
        if (lo > 5) return 1;
        pend = 2; p_idx = int'(lo); age = 0;
      end
      default: return 1;
    endcase
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_dig[i] = 7'h7F;
    m_mask = '0; sweep = -1; pend = 0; age = 0; ncyc = 0;
  endtask

  task automatic tick();
    logic [6:0] es [6];
    bit ee;
    bit off;
    off = ((ncyc / HALF) % 2) == 1;
    for (int i = 0; i < 6; i++) es[i] = (m_mask[i] && off) ? 7'h7F : m_dig[i];
    ee = 0;
    last_hs = Cmd_Valid && (sweep < 0);
    if (sweep >= 0) begin
      m_dig[sweep] = 7'h7F;
      if (sweep == 5) begin m_mask = '0; sweep = -1; end
      else sweep++;
    end else if (last_hs) ee = take(Cmd_Byte);
    else if (pend != 0) begin
      if (age == TMO - 1) begin pend = 0; ee = 1; end
      else age++;
    end
    @(posedge clk);
    #1;
    ncyc++;
    for (int i = 0; i < 6; i++) chk($sformatf("seg%0d@%0d", i, ncyc), 8'(seg[i]), 8'(es[i]));
    chk("ready", 8'(Cmd_Ready), 8'(sweep < 0));
    chk("busy", 8'(Busy), 8'(sweep >= 0));
    chk("err", 8'(Cmd_Err), 8'(ee));
  endtask

  task automatic do_reset();
    Reset_7Seg = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("rst_seg%0d", i), 8'(seg[i]), 8'h7F);
    chk("rst_ready", 8'(Cmd_Ready), 8'h01);
    chk("rst_busy", 8'(Busy), 8'h00);
    chk("rst_err", 8'(Cmd_Err), 8'h00);
    @(posedge clk);
    #1;
    Reset_7Seg = 1'b0;
  endtask

  task automatic send(logic [7:0] b);
    int g;
    Cmd_Valid = 1'b1;
    Cmd_Byte = b;
    g = 0;
    do begin tick(); g++; end while (!last_hs && g < 20);
    chk("accept", 8'(last_hs), 8'h01);
    Cmd_Valid = 1'b0;
    Cmd_Byte = 8'($urandom);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      Cmd_Byte = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    int n, errs, ch;
    logic [6:0] prev0, prev1;
    Reset_7Seg = 1'b0; Cmd_Valid = 1'b0; Cmd_Byte = 8'h00;
    #2;
    do_reset();
    // digit write lands on the output two cycles after the handshake
    send(8'h02);
    chk("t1_seg0_early", 8'(seg[0]), 8'h7F);
    tick();
    chk("t1_seg0", 8'(seg[0]), 8'h24);
    send(8'h5F);
    idle(1);
    chk("t2_seg5", 8'(seg[5]), 8'h0E);
    send(8'h6A);
    chk("t2_err", 8'(Cmd_Err), 8'h01);
    idle(3);
    send(8'hB3);
    send(8'h40);
    idle(1);
    chk("t3_raw", 8'(seg[3]), 8'h40);
    send(8'hB3);
    errs = 0;
    repeat (TMO + 4) begin tick(); errs += int'(Cmd_Err); end
    chk("t3_tmo_err", 8'(errs), 8'h01);
    chk("t3_unchanged", 8'(seg[3]), 8'h40);
    for (int i = 0; i < 6; i++) send(8'(i * 16 + 1));
    idle(2);
    Cmd_Valid = 1'b1;
    Cmd_Byte = 8'h80;
    tick();
    Cmd_Byte = 8'h17;
    n = 0;
    ch = 0;
    do begin n += int'(Busy); tick(); ch++; end while (!last_hs && ch < 20);
    Cmd_Valid = 1'b0;
    chk("t4_busy_cycles", 8'(n), 8'h06);
    idle(1);
    chk("t4_seg1", 8'(seg[1]), 8'h78);
    chk("t4_seg0", 8'(seg[0]), 8'h7F);
    send(8'h08);
    send(8'h5A);
    send(8'hA0);
    send(8'h21);
    idle(2);
    prev0 = seg[0];
    prev1 = seg[1];
    ch = 0;
    n = 0;
    repeat (64) begin
      tick();
      if (seg[0] !== prev0) ch++;
      if (seg[1] !== prev1) n++;
      prev0 = seg[0];
      prev1 = seg[1];
    end
    chk("t5_blink_toggles", 8'(ch), 8'h04);
    chk("t5_steady", 8'(n), 8'h00);
    send(8'hA0);
    idle(2);
    do_reset();
    send(8'h80);
    idle(2);
    do_reset();
    send(8'h34);
    idle(1);
    chk("t6_seg3", 8'(seg[3]), 8'h19);
    for (int k = 0; k < 400; k++) begin
      idle($urandom_range(0, 2));
      send(8'($urandom));
    end
    idle(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
